vpu_fp_cmp_core: RTL and testbench
==================================

// Module: vpu_fp_cmp_core
// PURPOSE
//  Pipelined floating-point compare responder for the AXI-stream-style interface used by VPU FP reduction ops (MAX3/MIN3 etc.).
//  Joins operand A and B beats, compares them and returns a 4-bit condition code {UN,GT,LT,EQ} plus a 1-bit invalid flag.
//  It is the in-house replacement for the vendor compare IP and is pin-compatible with it, plus one protocol-error output.
// PARAMETERS
//  EXP_W  8  exponent width (bf16 default)
//  MAN_W  7  stored mantissa width; DATA_W = 1+EXP_W+MAN_W (16 by default) must equal VPU_PKG::OPERAND_WIDTH
// PORTS
//  clk                   in   1       single clock, rising edge
//  rst_n                 in   1       asynchronous, active-low reset
//  s_axis_a_tvalid       in   1       operand A beat valid
//  s_axis_a_tdata        in   DATA_W  operand A
//  s_axis_b_tvalid       in   1       operand B beat valid
//  s_axis_b_tdata        in   DATA_W  operand B
//  m_axis_result_tvalid  out  1       result valid, single-cycle pulse per compare
//  m_axis_result_tdata   out  4       cmp_code_t: [3]UN [2]GT(A>B) [1]LT(A<B) [0]EQ
//  m_axis_result_tuser   out  1       invalid-op: either operand is a signalling NaN
//  proto_err_o           out  1       one-cycle pulse: pending operand overwritten
// BEHAVIOUR
//  Reset: all valids, pending flags, pipeline regs, outputs = 0. Reset is asynchronous and clears in-flight compares, which are dropped.
//  No tready: the block is always ready, and the consumer must accept every result.
//  Join: a compare issues when both A and B are available. Each is either on the bus this cycle or held in a one-entry pending register.
//   - A and B valid in the same cycle: issue directly. Any pending values stay untouched.
//   - Only one side valid, other side pending: issue using the pending value and clear that pending flag.
//   - Only one side valid, nothing to pair: capture it into its pending register and set its pending flag.
//   - Side valid while its own pending is already set and nothing to pair: overwrite the pending value and pulse proto_err_o on the next cycle.
//   - Both pending can never be set at the same time.
//  Pipeline: S1 registers classification of both operands and the unsigned magnitude compare. S2 resolves sign and NaN and registers the outputs.
//  Latency: exactly 2 cycles from issue to m_axis_result_tvalid. Throughput is 1 compare per cycle.
//  Classification (per operand):
//   - NaN: exp all-ones and mantissa != 0. sNaN: NaN with mantissa MSB = 0.
//   - Zero: exp = 0 and mantissa = 0. Subnormals are compared exactly, with no flush.
//  Result rules:
//   - Either operand is NaN: code = 4'b1000.
//   - Both zero, any sign: EQ, so +0 == -0.
//   - Signs differ: the positive operand is greater.
//   - Both positive: compare magnitude {exp,man}. Both negative: the inverted magnitude compare.
//   - Exactly one of GT, LT, EQ is set for ordered inputs. Inf is ordinary: +inf == +inf.
//  tuser = sNaN(A) | sNaN(B), aligned with tvalid. tdata and tuser hold their last value when tvalid = 0.
//  Back-to-back issues produce back-to-back results in order.
// STRUCTURE
//  VPU_PKG additions:
//   - typedef logic[3:0] cmp_code_t
//   - localparams CMP_EQ=4'b0001, CMP_LT=4'b0010, CMP_GT=4'b0100, CMP_UN=4'b1000
//   - typedef struct fp_class_t {sign, is_zero, is_nan, is_snan, mag}
//  Sub-module vpu_fp_classify (combinational unpack into fp_class_t), instantiated once for A and once for B.
//  Top level holds the join/pending logic and the 2-stage pipeline.
// TESTING
//  1 A=0x3F80(1.0), B=0x4000(2.0), both valid in cycle 0 -> tvalid in cycle 2, tdata=4'b0010, tuser=0.
//  2 A=0xBF80(-1.0), B=0x8000(-0) -> 0010. Then A=0x0000, B=0x8000 -> 0001. Then A=0x7F80, B=0x7F80 -> 0001.
//  3 A=0x7FC0(qNaN), B=0x3F80 -> 1000, tuser=0. Then A=0x3F80, B=0x7F81(sNaN) -> 1000, tuser=1.
//  4 A=0x4000 alone in cycle 0, B=0x3F80 alone in cycle 3 -> one result in cycle 5, tdata=0100, no proto_err_o.
//  5 A=0x4000 in cycle 0, A=0x3F80 in cycle 1, B=0x3F80 in cycle 2 -> proto_err_o pulses in cycle 2; result in cycle 4 is 0001.
//  6 Issue compares on 4 consecutive cycles and drop rst_n in cycle 3 -> outputs clear at once; no results after reset release.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU types: operand width, compare condition codes and the unpacked
// floating-point classification used by the compare pipeline.
package vpu_pkg;

  localparam int OPERAND_WIDTH = 16;
  localparam int MAG_W         = OPERAND_WIDTH - 1;

  typedef logic [3:0] cmp_code_t;

  localparam cmp_code_t CMP_EQ = 4'b0001;
  localparam cmp_code_t CMP_LT = 4'b0010;
  localparam cmp_code_t CMP_GT = 4'b0100;
  localparam cmp_code_t CMP_UN = 4'b1000;

  typedef struct packed {
    logic             sign;
    logic             is_zero;
    logic             is_nan;
    logic             is_snan;
    logic [MAG_W-1:0] mag;
  } fp_class_t;

  // Magnitude-free view of a classification, carried between pipeline stages
  typedef struct packed {
    logic sign;
    logic is_zero;
    logic is_nan;
    logic is_snan;
  } fp_flags_t;

endpackage

// File: rtl/vpu_fp_classify.sv
// Combinational unpack of one floating-point operand into sign, zero/NaN
// flags and the unsigned {exp,man} magnitude.
module vpu_fp_classify
  import vpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic [EXP_W+MAN_W:0] data_i,
  output fp_class_t            class_o
);

  localparam int DATA_W = 1 + EXP_W + MAN_W;

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = data_i[DATA_W-2:MAN_W];
  assign man_f = data_i[MAN_W-1:0];

  // A quiet NaN has the mantissa MSB set; any other NaN is signalling
  always_comb begin
    class_o         = '0;
    class_o.sign    = data_i[DATA_W-1];
    class_o.is_nan  = (&exp_f) && (|man_f);
    class_o.is_snan = (&exp_f) && (|man_f) && !man_f[MAN_W-1];
    class_o.is_zero = !(|exp_f) && !(|man_f);
    class_o.mag     = MAG_W'(data_i[DATA_W-2:0]);
  end

endmodule

// File: rtl/vpu_fp_cmp_core.sv
// Floating-point compare responder: joins A/B operand beats (with one-entry
// pending registers) and returns {UN,GT,LT,EQ} two cycles after issue.
module vpu_fp_cmp_core
  import vpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_a_tvalid,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_b_tvalid,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  output logic              m_axis_result_tvalid,
  output logic [3:0]        m_axis_result_tdata,
  output logic              m_axis_result_tuser,
  output logic              proto_err_o
);

  logic              a_pend_q, a_pend_d;
  logic              b_pend_q, b_pend_d;
  logic [DATA_W-1:0] a_hold_q, a_hold_d;
  logic [DATA_W-1:0] b_hold_q, b_hold_d;
  logic              proto_err_q, proto_err_d;

  logic              issue;
  logic [DATA_W-1:0] op_a, op_b;
  fp_class_t         cls_a, cls_b;

  logic              s1_valid_q, s1_valid_d;
  fp_flags_t         s1_a_q, s1_a_d;
  fp_flags_t         s1_b_q, s1_b_d;
  logic              s1_mag_gt_q, s1_mag_gt_d;
  logic              s1_mag_lt_q, s1_mag_lt_d;

  cmp_code_t         s2_code;
  logic              res_valid_q, res_valid_d;
  cmp_code_t         res_code_q, res_code_d;
  logic              res_user_q, res_user_d;

  // Join: a beat pairs with the bus or the other side's pending entry; an
  // unpaired beat lands in its own pending slot, flagging an overwrite.
  always_comb begin
    a_pend_d    = a_pend_q;
    b_pend_d    = b_pend_q;
    a_hold_d    = a_hold_q;
    b_hold_d    = b_hold_q;
    proto_err_d = 1'b0;
    issue       = 1'b0;
    op_a        = s_axis_a_tdata;
    op_b        = s_axis_b_tdata;
    if (s_axis_a_tvalid && s_axis_b_tvalid) begin
      issue = 1'b1;
    end else if (s_axis_a_tvalid) begin
      if (b_pend_q) begin
        issue    = 1'b1;
        op_b     = b_hold_q;
        b_pend_d = 1'b0;
      end else begin
        proto_err_d = a_pend_q;
        a_pend_d    = 1'b1;
        a_hold_d    = s_axis_a_tdata;
      end
    end else if (s_axis_b_tvalid) begin
      if (a_pend_q) begin
        issue    = 1'b1;
        op_a     = a_hold_q;
        a_pend_d = 1'b0;
      end else begin
        proto_err_d = b_pend_q;
        b_pend_d    = 1'b1;
        b_hold_d    = s_axis_b_tdata;
      end
    end
  end

  vpu_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_a (
    .data_i  (op_a),
    .class_o (cls_a)
  );

  vpu_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_classify_b (
    .data_i  (op_b),
    .class_o (cls_b)
  );

  always_comb begin
    s1_valid_d  = issue;
    s1_a_d      = '{sign: cls_a.sign, is_zero: cls_a.is_zero,
                    is_nan: cls_a.is_nan, is_snan: cls_a.is_snan};
    s1_b_d      = '{sign: cls_b.sign, is_zero: cls_b.is_zero,
                    is_nan: cls_b.is_nan, is_snan: cls_b.is_snan};
    s1_mag_gt_d = cls_a.mag > cls_b.mag;
    s1_mag_lt_d = cls_a.mag < cls_b.mag;
  end

  // Sign-magnitude resolution: for two negatives the magnitude order flips
  always_comb begin
    s2_code     = CMP_EQ;
    res_valid_d = s1_valid_q;
    res_code_d  = res_code_q;
    res_user_d  = res_user_q;
    if (s1_a_q.is_nan || s1_b_q.is_nan) begin
      s2_code = CMP_UN;
    end else if (s1_a_q.is_zero && s1_b_q.is_zero) begin
      s2_code = CMP_EQ;
    end else if (s1_a_q.sign != s1_b_q.sign) begin
      s2_code = s1_a_q.sign ? CMP_LT : CMP_GT;
    end else if (s1_mag_gt_q) begin
      s2_code = s1_a_q.sign ? CMP_LT : CMP_GT;
    end else if (s1_mag_lt_q) begin
      s2_code = s1_a_q.sign ? CMP_GT : CMP_LT;
    end
    if (s1_valid_q) begin
      res_code_d = s2_code;
      res_user_d = s1_a_q.is_snan || s1_b_q.is_snan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pend_q    <= 1'b0;
      b_pend_q    <= 1'b0;
      a_hold_q    <= '0;
      b_hold_q    <= '0;
      proto_err_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mag_gt_q <= 1'b0;
      s1_mag_lt_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_code_q  <= '0;
      res_user_q  <= 1'b0;
    end else begin
      a_pend_q    <= a_pend_d;
      b_pend_q    <= b_pend_d;
      a_hold_q    <= a_hold_d;
      b_hold_q    <= b_hold_d;
      proto_err_q <= proto_err_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mag_gt_q <= s1_mag_gt_d;
      s1_mag_lt_q <= s1_mag_lt_d;
      res_valid_q <= res_valid_d;
      res_code_q  <= res_code_d;
      res_user_q  <= res_user_d;
    end
  end

  assign m_axis_result_tvalid = res_valid_q;
  assign m_axis_result_tdata  = res_code_q;
  assign m_axis_result_tuser  = res_user_q;
  assign proto_err_o          = proto_err_q;

endmodule

// File: tb/tb_vpu_fp_cmp_core.sv
// Self-checking bench for vpu_fp_cmp_core: directed vectors plus random
// traffic, checked against a real-valued reference model.
module tb_vpu_fp_cmp_core;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aValid, bValid;
  logic [15:0] aData, bData;
  logic        resValid;
  logic [3:0]  resData;
  logic        resUser;
  logic        protoErr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit         expV[N];
  logic [3:0] expCode[N];
  bit         expUser[N];
  bit         expPerr[N];
  logic [3:0] lastCode;
  bit         lastUser;
  bit         pendA, pendB;
  logic [15:0] pendAData, pendBData;

  vpu_fp_cmp_core dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .s_axis_a_tvalid      (aValid),
    .s_axis_a_tdata       (aData),
    .s_axis_b_tvalid      (bValid),
    .s_axis_b_tdata       (bData),
    .m_axis_result_tvalid (resValid),
    .m_axis_result_tdata  (resData),
    .m_axis_result_tuser  (resUser),
    .proto_err_o          (protoErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic real fpVal(input logic [15:0] x);
    int  e;
    int  m;
    real v;
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    if (e == 255)    v = 1.0e300;
    else if (e == 0) v = m * (2.0 ** (-133));
    else             v = (1.0 + m / 128.0) * (2.0 ** (e - 127));
    return x[15] ? -v : v;
  endfunction

  function automatic bit isNan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'h0);
  endfunction

  function automatic bit isSnan(input logic [15:0] x);
    return isNan(x) && !x[6];
  endfunction

  function automatic logic [3:0] refCode(input logic [15:0] a, input logic [15:0] b);
    real va, vb;
    if (isNan(a) || isNan(b)) return 4'b1000;
    va = fpVal(a);
    vb = fpVal(b);
    if (va < vb) return 4'b0010;
    if (va > vb) return 4'b0100;
    return 4'b0001;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      expV[i] = 0; expCode[i] = 4'h0; expUser[i] = 0; expPerr[i] = 0;
    end
    lastCode = 4'h0; lastUser = 0;
    pendA = 0; pendB = 0; pendAData = 16'h0; pendBData = 16'h0;
  endtask

  task automatic modelIssue(input logic [15:0] a, input logic [15:0] b);
    int idx;
    idx = (cyc + 2) % N;
    expV[idx]    = 1;
    expCode[idx] = refCode(a, b);
    expUser[idx] = isSnan(a) || isSnan(b);
  endtask

  // One clock cycle: check outputs due now, then drive and model this cycle's beats
  task automatic applyStimulus(input bit av, input logic [15:0] a, input bit bv, input logic [15:0] b);
    int n;
    @(posedge clk);
    #1;
    n = cyc % N;
    if (expV[n]) begin
      lastCode = expCode[n];
      lastUser = expUser[n];
    end
    checkOutput("tvalid", 32'(resValid), 32'(expV[n]));
    checkOutput("tdata", 32'(resData), 32'(lastCode));
    checkOutput("tuser", 32'(resUser), 32'(lastUser));
    checkOutput("proto_err", 32'(protoErr), 32'(expPerr[n]));
    expV[n] = 0; expPerr[n] = 0;
    aValid = av; aData = av ? a : 16'h0;
    bValid = bv; bData = bv ? b : 16'h0;
    if (av && bv) begin
      modelIssue(a, b);
    end else if (av) begin
      if (pendB) begin
        modelIssue(a, pendBData);
        pendB = 0;
      end else begin
        if (pendA) expPerr[(cyc + 1) % N] = 1;
        pendA = 1; pendAData = a;
      end
    end else if (bv) begin
      if (pendA) begin
        modelIssue(pendAData, b);
        pendA = 0;
      end else begin
        if (pendB) expPerr[(cyc + 1) % N] = 1;
        pendB = 1; pendBData = b;
      end
    end
  endtask

  function automatic logic [15:0] randOp(input logic [15:0] other);
    logic [15:0] sp[12];
    int sel;
    sp = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h7F81,
           16'hFFC1, 16'h0001, 16'h8001, 16'h3F80, 16'hBF80, 16'h007F};
    sel = $urandom_range(0, 7);
    if (sel == 0) return sp[$urandom_range(0, 11)];
    if (sel == 1) return other;
    if (sel == 2) return other ^ 16'h8000;
    if (sel == 3) return other + 16'h0001;
    return 16'($urandom);
  endfunction

  task automatic idle(input int count);
    for (int i = 0; i < count; i++) applyStimulus(0, 16'h0, 0, 16'h0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0;
    aValid = 0; bValid = 0; aData = 16'h0; bData = 16'h0;
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tvalid", 32'(resValid), 32'h0);
    checkOutput("reset_tdata", 32'(resData), 32'h0);
    checkOutput("reset_tuser", 32'(resUser), 32'h0);
    checkOutput("reset_proto_err", 32'(protoErr), 32'h0);
    rst_n = 1'b1;

    applyStimulus(1, 16'h3F80, 1, 16'h4000);
    idle(3);
    applyStimulus(1, 16'hBF80, 1, 16'h8000);
    applyStimulus(1, 16'h0000, 1, 16'h8000);
    applyStimulus(1, 16'h7F80, 1, 16'h7F80);
    applyStimulus(1, 16'h7FC0, 1, 16'h3F80);
    applyStimulus(1, 16'h3F80, 1, 16'h7F81);
    idle(3);
    applyStimulus(1, 16'h4000, 0, 16'h0);
    idle(2);
    applyStimulus(0, 16'h0, 1, 16'h3F80);
    idle(3);
    applyStimulus(1, 16'h4000, 0, 16'h0);
    applyStimulus(1, 16'h3F80, 0, 16'h0);
    applyStimulus(0, 16'h0, 1, 16'h3F80);
    idle(3);

    for (int i = 0; i < 3; i++) applyStimulus(1, 16'h3F80, 1, 16'h4000 + 16'(i));
    @(posedge clk);
    #1;
    aValid = 1; aData = 16'hC000; bValid = 1; bData = 16'h4000;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tvalid", 32'(resValid), 32'h0);
    checkOutput("async_rst_tdata", 32'(resData), 32'h0);
    checkOutput("async_rst_tuser", 32'(resUser), 32'h0);
    checkOutput("async_rst_proto_err", 32'(protoErr), 32'h0);
    aValid = 0; bValid = 0; aData = 16'h0; bData = 16'h0;
    clearModel();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);

    for (int i = 0; i < 1500; i++) begin
      ra = 16'($urandom);
      rb = randOp(ra);
      ra = randOp(rb);
      applyStimulus($urandom_range(0, 2) != 0, ra, $urandom_range(0, 2) != 0, rb);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
